// File: rtl/dt_sti_loader.sv
// rtl/dt_sti_loader.sv - unpacks the 1-bit sti ROM image into the 8-bit res RAM object map
module dt_sti_loader #(
    parameter logic [7:0] FG_VALUE     = 8'd1,
    parameter bit         FORCE_BORDER = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        gnt,
    output logic        sti_rd,
    output logic [9:0]  sti_addr,
    input  logic [15:0] sti_di,
    output logic        res_wr,
    output logic [13:0] res_addr,
    output logic [7:0]  res_do,
    output logic        busy,
    output logic        done,
    output logic [14:0] fg_count
);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  w_q, w_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] word_q, word_d;
    logic [14:0] fg_q, fg_d;

    logic [13:0] pix_addr;
    logic [6:0]  row, col;
    logic        border;
    logic        pix_bit;
    logic [7:0]  pix_val;

    always_comb begin
        pix_addr = {w_q, idx_q};
        row      = pix_addr[13:7];
        col      = pix_addr[6:0];
        border   = FORCE_BORDER &&
                   (row == 7'd0 || row == 7'd127 || col == 7'd0 || col == 7'd127);
        // bit 15 is the leftmost pixel, so idx 0 maps to the MSB
        pix_bit  = word_q[4'd15 - idx_q];
        pix_val  = (pix_bit && !border) ? FG_VALUE : 8'd0;
    end

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        idx_d    = idx_q;
        word_d   = word_q;
        fg_d     = fg_q;
        sti_rd   = 1'b0;
        sti_addr = 10'd0;
        res_wr   = 1'b0;
        res_addr = 14'd0;
        res_do   = 8'd0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!abort && start) begin
                    state_d = FETCH;
                    w_d     = 10'd0;
                    fg_d    = 15'd0;
                end
            end
            FETCH: begin
                busy     = 1'b1;
                sti_rd   = 1'b1;
                sti_addr = w_q;
                word_d   = sti_di;
                idx_d    = 4'd0;
                state_d  = abort ? IDLE : WRITE;
            end
            WRITE: begin
                busy     = 1'b1;
                res_addr = pix_addr;
                res_do   = pix_val;
                res_wr   = gnt;
                if (gnt) begin
                    idx_d = idx_q + 4'd1;
                    if (pix_val != 8'd0) begin
                        fg_d = fg_q + 15'd1;
                    end
                    if (idx_q == 4'd15) begin
                        if (w_q != 10'd1023) begin
                            // prefetch the next word while the last pixel is written
                            sti_rd   = 1'b1;
                            sti_addr = w_q + 10'd1;
                            w_d      = w_q + 10'd1;
                            word_d   = sti_di;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                if (abort) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fg_count = fg_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            w_q     <= 10'd0;
            idx_q   <= 4'd0;
            word_q  <= 16'd0;
            fg_q    <= 15'd0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            fg_q    <= fg_d;
        end
    end

endmodule

// File: doc/dt_sti_loader.md
Name: dt_sti_loader

Overview:
- Sequences the initial load phase of the DT engine.
- Streams the packed 1-bit source image (1024 words × 16 pixels = 128×128) out of the sti ROM and unpacks it.
- Writes one 8-bit pixel per granted cycle into the 16384-entry result RAM, producing the 0/object map that the forward pass consumes.
- A shared-port arbiter sits between this block and the res RAM; it grants the write port through gnt.

Parameters:
- FG_VALUE, 8'd1, value written to res RAM for an object pixel (bit = 1); background pixels are always 8'd0.
- FORCE_BORDER, 0, when 1, pixels in row 0, row 127, column 0 or column 127 are written as 0 regardless of the source bit.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE on the next posedge, no done pulse.
- gnt  input  1  res RAM write-port grant from the arbiter.
- sti_rd  output  1  sti ROM read enable (ROM samples addr at negedge).
- sti_addr  output  10  sti ROM word address.
- sti_di  input  16  sti ROM data; bit 15 is the leftmost pixel of the word.
- res_wr  output  1  res RAM write enable (RAM writes at posedge).
- res_addr  output  14  res RAM pixel address = {word index, pixel index}.
- res_do  output  8  res RAM write data.
- busy  output  1  high in FETCH and WRITE.
- done  output  1  one-cycle pulse when the last pixel has been written.
- fg_count  output  15  number of FG_VALUE pixels written in the current/last load.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE; w = 0, idx = 0, word register = 0, fg_count = 0. All outputs are 0.
- State IDLE: outputs low; fg_count holds.
  - start = 1 -> FETCH; w <= 0; fg_count <= 0.
- State FETCH (one cycle): sti_rd = 1, sti_addr = w. Next posedge: word <= sti_di, idx <= 0 -> WRITE.
- State WRITE:
  - res_addr = {w, idx}.
  - bit = word[15 - idx].
  - res_do = (bit and not border) ? FG_VALUE : 0.
  - res_wr = gnt (combinational).
- gnt = 0: no write; idx, w and word hold; sti_rd = 0. Stalls of any length are legal.
- gnt = 1:
  - idx <= idx + 1 (4-bit wrap).
  - fg_count increments if res_do != 0.
- gnt = 1 and idx = 15 and w != 1023 (prefetch):
  - sti_rd = 1, sti_addr = w + 1 in the same cycle.
  - Next posedge: w <= w + 1, word <= sti_di.
  - No bubble between words.
- gnt = 1 and idx = 15 and w = 1023: sti_rd = 0 -> DONE.
- State DONE (one cycle): done = 1, busy = 0, all RAM/ROM strobes 0 -> IDLE. fg_count holds its final value until the next accepted start.
- Border (FORCE_BORDER = 1):
  - row = {w, idx}[13:7], col = {w, idx}[6:0].
  - A pixel is border if row ∈ {0, 127} or col ∈ {0, 127}.
- Latency with gnt held high: start accepted at edge T0; first res_wr in cycle T1 -> T2; last write in cycle T16384 -> T16385; done high in cycle T16385 -> T16386.
- start while busy or in DONE: ignored.
- abort: highest priority after reset; from FETCH or WRITE -> IDLE at the next posedge. A write already presented with gnt = 1 in that cycle still occurs. No done pulse; fg_count holds a partial value.
- abort and start in the same IDLE cycle: abort wins, stay IDLE.
- Reset mid-load: immediate return to IDLE with all outputs 0. Partially written RAM contents are not cleaned up.
- fg_count never saturates: maximum is 16384, which fits in 15 bits.

Test Plan:
- Full load, gnt = 1, sti word0 = 16'h8001, all other words 0 -> RAM[0] = 1, RAM[1..14] = 0, RAM[15] = 1, all others 0; done pulses exactly 16386 cycles after the start edge; fg_count = 2.
- All-ones image, FORCE_BORDER = 1 -> RAM[0..127] = 0, RAM[129] = 1, RAM[255] = 0, RAM[16256..16383] = 0; fg_count = 126 × 126 = 15876.
- gnt toggling 1,0,1,0 with a random image -> res contents match the unpacked image bit-for-bit; each sti_addr is read once per prefetch/fetch; done at 2 × 16384 + 2 cycles.
- abort asserted at pixel 5000 -> no further res_wr after the next edge; done never pulses; busy = 0; a new start completes a correct full load.
- reset pulled low mid-WRITE -> all outputs 0 in the same cycle; after release, no activity until start.
- start pulsed during WRITE and in the DONE cycle -> ignored; exactly one done pulse and one load sequence.
